// File: rtl/beam_pkg.sv
// Shared constants and FSM state type for the beamforming delay path.
// The sine lookup and the pulse schedulers import the same defaults.
package beam_pkg;

    localparam int unsigned DEF_NUM_ELEMENTS = 8;
    localparam int unsigned DEF_SIN_WIDTH    = 16;
    localparam int unsigned DEF_DELAY_WIDTH  = 16;

    localparam int unsigned CLK_FREQ_HZ        = 100_000_000;
    localparam int unsigned SPEED_OF_SOUND_MPS = 343;
    localparam int unsigned ELEMENT_PITCH_UM   = 4300;

    // Element pitch divided by speed of sound, rounded to whole clock cycles (1254)
    localparam int unsigned DEF_ELEMENT_SPACING_CYCLES =
        (ELEMENT_PITCH_UM * (CLK_FREQ_HZ / 1_000_000) + SPEED_OF_SOUND_MPS / 2)
        / SPEED_OF_SOUND_MPS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_BASE = 2'd2,
        ST_EMIT = 2'd3
    } beam_state_e;

endpackage

// File: rtl/beam_delay_calc_if.sv
// Valid/ready stream of per-element firing delays towards the pulse schedulers.
interface beam_delay_calc_if
    import beam_pkg::*;
#(
    parameter int unsigned NUM_ELEMENTS = DEF_NUM_ELEMENTS,
    parameter int unsigned DELAY_WIDTH  = DEF_DELAY_WIDTH
);

    logic                            out_valid;
    logic                            out_ready;
    logic [$clog2(NUM_ELEMENTS)-1:0] idx_out;
    logic [DELAY_WIDTH-1:0]          delay_out;

    modport master (
        output out_valid,
        output idx_out,
        output delay_out,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  idx_out,
        input  delay_out,
        output out_ready
    );

endinterface

// File: rtl/beam_delay_calc.sv
// Turns one latched |sin| / sign sample into a stream of non-negative per-element
// firing delays; the sign picks which end of the array fires first.
module beam_delay_calc
    import beam_pkg::*;
#(
    parameter int unsigned NUM_ELEMENTS           = DEF_NUM_ELEMENTS,
    parameter int unsigned ELEMENT_SPACING_CYCLES = DEF_ELEMENT_SPACING_CYCLES,
    parameter int unsigned SIN_WIDTH              = DEF_SIN_WIDTH,
    parameter int unsigned DELAY_WIDTH            = DEF_DELAY_WIDTH
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic [SIN_WIDTH-1:0] sin_value_in,
    input  logic                 sin_sign_in,
    beam_delay_calc_if.master    out_if,
    output logic                 busy_out,
    output logic                 done_out
);

    localparam int unsigned IDX_W  = $clog2(NUM_ELEMENTS);
    localparam int unsigned PROD_W = SIN_WIDTH + $clog2(ELEMENT_SPACING_CYCLES + 1);
    localparam int unsigned RND_W  = PROD_W + 1;
    localparam int unsigned STEP_W = RND_W - SIN_WIDTH;
    localparam int unsigned ACC_W  = DELAY_WIDTH + IDX_W;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_ELEMENTS - 1);
    localparam logic [RND_W-1:0] HALF_LSB  = RND_W'(1) << (SIN_WIDTH - 1);
    localparam logic [ACC_W-1:0] DELAY_MAX = ACC_W'({DELAY_WIDTH{1'b1}});

    beam_state_e            state_q, state_d;
    logic [SIN_WIDTH-1:0]   sin_q, sin_d;
    logic                   sign_q, sign_d;
    logic [STEP_W-1:0]      step_q, step_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DELAY_WIDTH-1:0] delay_q, delay_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [PROD_W-1:0]      prod;
    logic [RND_W-1:0]       prod_rnd;
    logic [ACC_W-1:0]       acc_next;

    function automatic logic [DELAY_WIDTH-1:0] sat_delay(input logic [ACC_W-1:0] a);
        return (a > DELAY_MAX) ? DELAY_WIDTH'(DELAY_MAX) : DELAY_WIDTH'(a);
    endfunction

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d = state_q;
        sin_d   = sin_q;
        sign_d  = sign_q;
        step_d  = step_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        delay_d = delay_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        prod     = PROD_W'(sin_q) * PROD_W'(ELEMENT_SPACING_CYCLES);
        prod_rnd = RND_W'(prod) + HALF_LSB;
        // Negative angles walk down from the far end and land exactly on zero
        acc_next = sign_q ? (acc_q - ACC_W'(step_q)) : (acc_q + ACC_W'(step_q));

        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    sin_d   = sin_value_in;
                    sign_d  = sin_sign_in;
                    busy_d  = 1'b1;
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                step_d  = STEP_W'(prod_rnd >> SIN_WIDTH);
                state_d = ST_BASE;
            end
            ST_BASE: begin
                acc_d   = sign_q ? (ACC_W'(step_q) * ACC_W'(NUM_ELEMENTS - 1)) : '0;
                idx_d   = '0;
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (!valid_q) begin
                    valid_d = 1'b1;
                    delay_d = sat_delay(acc_q);
                end else if (out_if.out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        idx_d   = '0;
                        delay_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        acc_d   = acc_next;
                        delay_d = sat_delay(acc_next);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            sin_q   <= '0;
            sign_q  <= 1'b0;
            step_q  <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            delay_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sin_q   <= sin_d;
            sign_q  <= sign_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            delay_q <= delay_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out_if.out_valid = valid_q;
    assign out_if.idx_out   = idx_q;
    assign out_if.delay_out = delay_q;
    assign busy_out         = busy_q;
    assign done_out         = done_q;

endmodule

// File: doc/beam_delay_calc.md
Name: beam_delay_calc

Overview:
Converts one steering-angle sine sample from the angle-to-sine lookup into per-transducer firing delays, in clock cycles, for the linear ultrasonic array. It latches the sine magnitude and sign on a start pulse and computes the inter-element step, step = spacing_cycles * sin. It then streams one delay per element (index 0..N-1) over a valid/ready interface to the per-channel pulse schedulers. All emitted delays are non-negative; the sign selects which end of the array fires first.

Parameters:
NUM_ELEMENTS, 8, number of transducers; must be >= 2.
ELEMENT_SPACING_CYCLES, 1254, element pitch divided by speed of sound, in clk_in cycles (4.3 mm / 343 m/s at 100 MHz).
SIN_WIDTH, 16, width of the unsigned sine magnitude; full scale 2^SIN_WIDTH-1 represents 1.0.
DELAY_WIDTH, 16, width of each output delay.

Ports:
clk_in  input  1  system clock; the only clock.
rst_in  input  1  reset; synchronous, active-high.
start_in  input  1  one-cycle request to compute a delay set; sampled only in IDLE.
sin_value_in  input  SIN_WIDTH  |sin(theta)| from the sine lookup.
sin_sign_in  input  1  1 = negative angle.
out_valid  output  1  delay_out and idx_out are valid.
out_ready  input  1  consumer accepts the current delay.
idx_out  output  $clog2(NUM_ELEMENTS)  element index of delay_out.
delay_out  output  DELAY_WIDTH  firing delay in cycles.
busy_out  output  1  high from start acceptance until the last transfer.
done_out  output  1  one-cycle pulse after the final transfer.

Behaviour:
- Reset: on any rising clk_in edge with rst_in=1, the FSM goes to IDLE and every output goes to 0 (out_valid, idx_out, delay_out, busy_out, done_out). This applies in any state, including mid-stream; the partial stream is abandoned and no done_out is issued.
- FSM states and transitions:
  - IDLE: if start_in=1, latch sin_value_in and sin_sign_in, set busy_out=1, go to STEP. Inputs are latched because the upstream angle may change afterwards.
  - STEP: step = (sin_latched * ELEMENT_SPACING_CYCLES + 2^(SIN_WIDTH-1)) >> SIN_WIDTH, i.e. round-half-up. The product width is SIN_WIDTH + clog2(ELEMENT_SPACING_CYCLES+1). Register step, go to BASE.
  - BASE: accumulator = sign ? (NUM_ELEMENTS-1)*step : 0, computed at DELAY_WIDTH+clog2(NUM_ELEMENTS) bits. idx = 0. Go to EMIT.
  - EMIT: out_valid=1. delay_out = accumulator, saturated to 2^DELAY_WIDTH-1 if it overflows DELAY_WIDTH.
    - On out_valid & out_ready: idx advances by 1, and the accumulator adds step (sign=0) or subtracts step (sign=1).
    - On the transfer with idx = NUM_ELEMENTS-1: go to IDLE, drop out_valid and busy_out, and pulse done_out in the next cycle.
- Latency: start accepted at edge 0, so out_valid is first high after edge 3 (STEP and BASE each take one cycle). With out_ready held high, one delay transfers per cycle; done_out is high in the cycle after the last transfer.
- Handshake: while out_valid=1 and out_ready=0, idx_out and delay_out hold stable. out_valid never drops before its transfer.
- Ordering: idx_out is strictly 0,1,...,N-1. Element delays are delay_i = i*step for sign=0 and (N-1-i)*step for sign=1.
- start_in while busy_out=1 is ignored, with no queuing. start_in in the cycle done_out is high is accepted, because the FSM is already in IDLE.
- sin_value_in=0 gives step=0 and all delays 0 regardless of sign.
- The accumulator never underflows: in the sign=1 path it reaches exactly 0 at idx N-1.

Decomposition:
- Shared package beam_pkg holds:
  - the FSM state enum (IDLE, STEP, BASE, EMIT);
  - defaults for NUM_ELEMENTS, ELEMENT_SPACING_CYCLES and SPEED_OF_SOUND-derived constants, shared with the sine lookup and the pulse schedulers.
- No sub-module; the single multiply, the constant multiply and the accumulator stay inline.

Test Plan:
- sin=0, sign=0, start, out_ready=1 -> 8 transfers, idx 0..7, all delay 0; done_out pulses once; busy_out low afterwards.
- sin=65535, sign=0 -> step 1254; delays 0,1254,2508,...,8778; first out_valid exactly 3 cycles after start.
- sin=32768, sign=1 -> step 627; delays 4389,3762,3135,2508,1881,1254,627,0 for idx 0..7.
- sin=65535 with out_ready toggling 1,0,0,1,...; start_in pulsed mid-stream -> data holds while out_ready=0; sequence identical to the second scenario; the extra start is ignored (exactly one done_out).
- rst_in=1 during EMIT at idx 3 -> next edge all outputs 0, no done_out; a fresh start (sin=65535, sign=0) yields the full correct 8-element sequence.
- DELAY_WIDTH=12, sin=65535, sign=0 -> delays 0,1254,2508,3762, then 4095 for idx 4..7 (saturation).
